// File: rtl/mmv_pkg.sv
// Shared types for the memory-mapped pipeline buffer.
// The request struct here uses the default 8-bit address/data widths.
// Instances with other widths declare a local struct with the same field
// order and hand it to the FIFO as a type parameter.
package mmv_pkg;

    localparam int MMV_AWIDTH_DEF = 8;
    localparam int MMV_DWIDTH_DEF = 8;

    typedef struct packed {
        logic [MMV_AWIDTH_DEF-1:0] addr;
        logic                      wreq;
        logic                      rreq;
        logic [MMV_DWIDTH_DEF-1:0] wdat;
    } mmv_req_t;

endpackage

// File: rtl/mmv_req_fifo.sv
// Request FIFO of DEPTH entries, where DEPTH is a power of 2.
// The head is read straight out of the storage registers, so it comes from
// registers only. The empty and full flags are registered from the next
// count, so no input reaches any output in the same cycle.
module mmv_req_fifo
    import mmv_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type req_t = mmv_req_t
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  req_t push_req,
    input  logic pop,
    output req_t head,
    output logic empty,
    output logic full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    req_t          mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rptr];

    // Compute the next occupancy. A push and a pop in the same cycle cancel.
    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Write into storage. Reset clears it so that m_addr and m_wdat read 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wptr] <= push_req;
        end
    end

    // Update the pointers, the count and the registered flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == DEPTH_C);
        end
    end

endmodule

// File: rtl/mmv_pipe_buffer.sv
// Memory-mapped pipeline buffer. A DEPTH-entry request FIFO sits between the
// master and the slave, and the number of reads in flight is capped at RDPEND.
// Optional macro MMV_PIPE_BUFFER_RDREG_EN registers the read-return path;
// when it is not defined, the read return passes straight through.
module mmv_pipe_buffer
    import mmv_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4,
    parameter int RDPEND = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [AWIDTH-1:0]               s_addr,
    input  logic                            s_wreq,
    input  logic [DWIDTH-1:0]               s_wdat,
    input  logic                            s_rreq,
    output logic [DWIDTH-1:0]               s_rdat,
    output logic                            s_rval,
    output logic                            s_busy,
    output logic [AWIDTH-1:0]               m_addr,
    output logic                            m_wreq,
    output logic [DWIDTH-1:0]               m_wdat,
    output logic                            m_rreq,
    input  logic [DWIDTH-1:0]               m_rdat,
    input  logic                            m_rval,
    input  logic                            m_busy,
    output logic [$clog2(RDPEND+1)-1:0]     rd_pend,
    output logic                            rd_err
);

    localparam int PW = $clog2(RDPEND + 1);
    localparam logic [PW-1:0] RDPEND_C = PW'(RDPEND);

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic              wreq;
        logic              rreq;
        logic [DWIDTH-1:0] wdat;
    } req_t;

    req_t push_req;
    req_t head;
    logic empty;
    logic full;
    logic push;
    logic pop;
    logic rd_ok;
    logic rd_inc;

    assign push_req = '{addr: s_addr, wreq: s_wreq, rreq: s_rreq, wdat: s_wdat};
    assign push     = (s_wreq | s_rreq) & ~full;
    assign s_busy   = full;

    // A read at the head waits for a free read slot. Anything queued behind it
    // waits too, so the request order is kept.
    assign rd_ok  = ~head.rreq | (rd_pend < RDPEND_C);
    assign m_wreq = head.wreq & ~empty & rd_ok;
    assign m_rreq = head.rreq & ~empty & rd_ok;
    assign m_addr = head.addr;
    assign m_wdat = head.wdat;
    assign pop    = (m_wreq | m_rreq) & ~m_busy;
    assign rd_inc = pop & head.rreq;

    mmv_req_fifo #(
        .DEPTH (DEPTH),
        .req_t (req_t)
    ) u_req_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .full     (full)
    );

    // Track outstanding reads. A return with nothing outstanding is flagged
    // as an error, and that flag stays set until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= '0;
            rd_err  <= 1'b0;
        end else begin
            case ({rd_inc, m_rval})
                2'b10:   rd_pend <= rd_pend + 1'b1;
                2'b01:   if (rd_pend != '0) rd_pend <= rd_pend - 1'b1;
                default: rd_pend <= rd_pend;
            endcase
            if (m_rval && (rd_pend == '0)) rd_err <= 1'b1;
        end
    end

`ifdef MMV_PIPE_BUFFER_RDREG_EN
    // Registered read return: one cycle of latency, no combinational path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_rdat <= '0;
            s_rval <= 1'b0;
        end else begin
            s_rdat <= m_rdat;
            s_rval <= m_rval;
        end
    end
`else
    assign s_rdat = m_rdat;
    assign s_rval = m_rval;
`endif

endmodule

// File: tb/tb_mmv_pipe_buffer.sv
// Directed testbench for mmv_pipe_buffer with DEPTH=4 and RDPEND=2.
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge as well, or #1 after it when the check concerns same-cycle behaviour.
module tb_mmv_pipe_buffer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] s_addr;
    logic       s_wreq;
    logic [7:0] s_wdat;
    logic       s_rreq;
    logic [7:0] s_rdat;
    logic       s_rval;
    logic       s_busy;
    logic [7:0] m_addr;
    logic       m_wreq;
    logic [7:0] m_wdat;
    logic       m_rreq;
    logic [7:0] m_rdat;
    logic       m_rval;
    logic       m_busy;
    logic [1:0] rd_pend;
    logic       rd_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmv_pipe_buffer #(
        .AWIDTH (8),
        .DWIDTH (8),
        .DEPTH  (4),
        .RDPEND (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_addr  (s_addr),
        .s_wreq  (s_wreq),
        .s_wdat  (s_wdat),
        .s_rreq  (s_rreq),
        .s_rdat  (s_rdat),
        .s_rval  (s_rval),
        .s_busy  (s_busy),
        .m_addr  (m_addr),
        .m_wreq  (m_wreq),
        .m_wdat  (m_wdat),
        .m_rreq  (m_rreq),
        .m_rdat  (m_rdat),
        .m_rval  (m_rval),
        .m_busy  (m_busy),
        .rd_pend (rd_pend),
        .rd_err  (rd_err)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_rval();
        m_rval = 1'b1;
        step();
        m_rval = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({m_wreq, m_rreq, s_busy, s_rval, rd_err, m_addr, m_wdat, s_rdat, rd_pend} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wreq=%b rreq=%b busy=%b rval=%b err=%b addr=%h wdat=%h rdat=%h pend=%0d, want all 0",
                     m_wreq, m_rreq, s_busy, s_rval, rd_err, m_addr, m_wdat, s_rdat, rd_pend);
        end
    endtask

    task automatic test_single_write();
        s_wreq = 1'b1; s_addr = 8'h12; s_wdat = 8'hA5;
        #1;
        checks++;
        if (m_wreq !== 1'b0) begin
            errors++; $display("FAIL sw_no_comb: m_wreq got %b want 0", m_wreq);
        end
        step();
        s_wreq = 1'b0;
        checks++;
        if (m_wreq !== 1'b1 || m_addr !== 8'h12 || m_wdat !== 8'hA5) begin
            errors++;
            $display("FAIL sw_present: got wreq=%b addr=%h wdat=%h want 1/12/a5", m_wreq, m_addr, m_wdat);
        end
        step();
        checks++;
        if (m_wreq !== 1'b0) begin
            errors++; $display("FAIL sw_one_cycle: m_wreq got %b want 0", m_wreq);
        end
    endtask

    task automatic test_back_to_back();
        logic       exp_r;
        logic [7:0] exp_a;
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) begin
                exp_a = 8'h30 + 8'(i - 1);
                exp_r = (i == 3);
                checks++;
                if (m_wreq !== 1'b1 || m_rreq !== exp_r || m_addr !== exp_a || m_wdat !== 8'h80 + 8'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_entry%0d: got wreq=%b rreq=%b addr=%h wdat=%h want 1/%b/%h/%h",
                             i - 1, m_wreq, m_rreq, m_addr, m_wdat, exp_r, exp_a, 8'h80 + 8'(i - 1));
                end
            end
            if (i < 3) begin
                s_wreq = 1'b1; s_rreq = (i == 2);
                s_addr = 8'h30 + 8'(i); s_wdat = 8'h80 + 8'(i);
            end else begin
                s_wreq = 1'b0; s_rreq = 1'b0;
            end
            step();
        end
        checks++;
        if (m_wreq !== 1'b0 || rd_pend !== 2'd1) begin
            errors++; $display("FAIL b2b_drained: got wreq=%b pend=%0d want 0/1", m_wreq, rd_pend);
        end
        m_rval = 1'b1; m_rdat = 8'h3C;
        #1;
`ifndef MMV_PIPE_BUFFER_RDREG_EN
        checks++;
        if (s_rval !== 1'b1 || s_rdat !== 8'h3C) begin
            errors++; $display("FAIL ret_comb: got rval=%b rdat=%h want 1/3c", s_rval, s_rdat);
        end
`endif
        step();
        m_rval = 1'b0; m_rdat = 8'h00;
        #1;
`ifdef MMV_PIPE_BUFFER_RDREG_EN
        checks++;
        if (s_rval !== 1'b1 || s_rdat !== 8'h3C) begin
            errors++; $display("FAIL ret_reg: got rval=%b rdat=%h want 1/3c", s_rval, s_rdat);
        end
`else
        checks++;
        if (s_rval !== 1'b0) begin
            errors++; $display("FAIL ret_comb_low: s_rval got %b want 0", s_rval);
        end
`endif
        checks++;
        if (rd_pend !== 2'd0) begin
            errors++; $display("FAIL ret_pend: rd_pend got %0d want 0", rd_pend);
        end
    endtask

    task automatic test_full();
        m_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_busy !== 1'b0) begin
                errors++; $display("FAIL full_early_busy%0d: s_busy got %b want 0", i, s_busy);
            end
            s_wreq = 1'b1; s_addr = 8'h20 + 8'(i); s_wdat = 8'h40 + 8'(i);
            step();
        end
        s_wreq = 1'b0;
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (s_busy !== 1'b1 || m_wreq !== 1'b1 || m_addr !== 8'h20 || m_wdat !== 8'h40) begin
                errors++;
                $display("FAIL full_hold%0d: got busy=%b wreq=%b addr=%h wdat=%h want 1/1/20/40",
                         j, s_busy, m_wreq, m_addr, m_wdat);
            end
            step();
        end
        m_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_wreq !== 1'b1 || m_addr !== 8'h20 + 8'(i) || m_wdat !== 8'h40 + 8'(i) || s_busy !== (i == 0)) begin
                errors++;
                $display("FAIL full_pop%0d: got wreq=%b addr=%h wdat=%h busy=%b want 1/%h/%h/%b",
                         i, m_wreq, m_addr, m_wdat, s_busy, 8'h20 + 8'(i), 8'h40 + 8'(i), (i == 0));
            end
            step();
        end
        checks++;
        if (m_wreq !== 1'b0 || s_busy !== 1'b0) begin
            errors++; $display("FAIL full_empty: got wreq=%b busy=%b want 0/0", m_wreq, s_busy);
        end
    endtask

    task automatic test_read_cap();
        for (int i = 0; i < 3; i++) begin
            s_rreq = 1'b1; s_addr = 8'h50 + 8'(i);
            step();
        end
        s_rreq = 1'b0;
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (rd_pend !== 2'd2 || m_rreq !== 1'b0 || m_addr !== 8'h52) begin
                errors++;
                $display("FAIL cap_hold%0d: got pend=%0d rreq=%b addr=%h want 2/0/52", j, rd_pend, m_rreq, m_addr);
            end
            step();
        end
        m_rval = 1'b1;
        #1;
        checks++;
        if (m_rreq !== 1'b0) begin
            errors++; $display("FAIL cap_no_comb: m_rreq got %b want 0", m_rreq);
        end
        step();
        m_rval = 1'b0;
        checks++;
        if (rd_pend !== 2'd1 || m_rreq !== 1'b1 || m_addr !== 8'h52) begin
            errors++;
            $display("FAIL cap_release: got pend=%0d rreq=%b addr=%h want 1/1/52", rd_pend, m_rreq, m_addr);
        end
        step();
        checks++;
        if (rd_pend !== 2'd2 || m_rreq !== 1'b0) begin
            errors++; $display("FAIL cap_after: got pend=%0d rreq=%b want 2/0", rd_pend, m_rreq);
        end
    endtask

    task automatic test_same_cycle();
        pulse_rval();
        checks++;
        if (rd_pend !== 2'd1) begin
            errors++; $display("FAIL sc_pre: rd_pend got %0d want 1", rd_pend);
        end
        s_rreq = 1'b1; s_addr = 8'h5A;
        step();
        s_rreq = 1'b0;
        checks++;
        if (m_rreq !== 1'b1 || rd_pend !== 2'd1) begin
            errors++; $display("FAIL sc_present: got rreq=%b pend=%0d want 1/1", m_rreq, rd_pend);
        end
        pulse_rval();
        checks++;
        if (rd_pend !== 2'd1 || m_rreq !== 1'b0) begin
            errors++; $display("FAIL sc_both: got pend=%0d rreq=%b want 1/0", rd_pend, m_rreq);
        end
        pulse_rval();
        checks++;
        if (rd_pend !== 2'd0 || rd_err !== 1'b0) begin
            errors++; $display("FAIL sc_drain: got pend=%0d err=%b want 0/0", rd_pend, rd_err);
        end
        pulse_rval();
        checks++;
        if (rd_pend !== 2'd0 || rd_err !== 1'b1) begin
            errors++; $display("FAIL sc_underflow: got pend=%0d err=%b want 0/1", rd_pend, rd_err);
        end
        step();
        step();
        checks++;
        if (rd_err !== 1'b1) begin
            errors++; $display("FAIL sc_sticky: rd_err got %b want 1", rd_err);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            s_rreq = 1'b1; s_addr = 8'h60 + 8'(i);
            step();
        end
        s_rreq = 1'b0;
        checks++;
        if (rd_pend !== 2'd2 || m_rreq !== 1'b0 || m_addr !== 8'h62 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_setup: got pend=%0d rreq=%b addr=%h busy=%b want 2/0/62/0", rd_pend, m_rreq, m_addr, s_busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({m_wreq, m_rreq, s_busy, s_rval, rd_err, m_addr, m_wdat, s_rdat, rd_pend} !== '0) begin
            errors++;
            $display("FAIL rm_async: got wreq=%b rreq=%b busy=%b rval=%b err=%b addr=%h wdat=%h rdat=%h pend=%0d, want all 0",
                     m_wreq, m_rreq, s_busy, s_rval, rd_err, m_addr, m_wdat, s_rdat, rd_pend);
        end
        step();
        reset_n = 1'b1;
        step();
        step();
        checks++;
        if (m_wreq !== 1'b0 || m_rreq !== 1'b0 || rd_pend !== 2'd0 || rd_err !== 1'b0) begin
            errors++;
            $display("FAIL rm_no_stale: got wreq=%b rreq=%b pend=%0d err=%b want 0/0/0/0", m_wreq, m_rreq, rd_pend, rd_err);
        end
        s_wreq = 1'b1; s_addr = 8'h77; s_wdat = 8'h99;
        step();
        s_wreq = 1'b0;
        checks++;
        if (m_wreq !== 1'b1 || m_rreq !== 1'b0 || m_addr !== 8'h77 || m_wdat !== 8'h99) begin
            errors++;
            $display("FAIL rm_fresh: got wreq=%b rreq=%b addr=%h wdat=%h want 1/0/77/99", m_wreq, m_rreq, m_addr, m_wdat);
        end
        step();
        pulse_rval();
        checks++;
        if (rd_err !== 1'b1) begin
            errors++; $display("FAIL rm_late_rval: rd_err got %b want 1", rd_err);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        s_addr = '0; s_wreq = 1'b0; s_wdat = '0; s_rreq = 1'b0;
        m_rdat = '0; m_rval = 1'b0; m_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        test_single_write();
        test_back_to_back();
        test_full();
        test_read_cap();
        test_same_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
